fact_accel: RTL and testbench
=============================

FACT_ACCEL -- requirements
Module: fact_accel

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus and result width.
REQ-002 SHALL have parameter N_W, default 4, meaning width of the operand N register.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port we  input  1  write strobe from CPU bus, sampled on rising clk.
REQ-006 SHALL have port a  input  2  word register select: 0=N, 1=GO, 2=STATUS, 3=RESULT.
REQ-007 SHALL have port wd  input  DATA_W  write data.
REQ-008 SHALL have port rd  output  DATA_W  read data, combinational from a.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-010 SHALL update reg N from wd[N_W-1:0] when we=1 and a=0, in any state.
REQ-011 SHALL treat we=1, a=1, wd[0]=1 in IDLE or DONE as GO: latch N into working count, clear done/err, next state BUSY.
REQ-012 SHALL ignore GO while BUSY; no restart, no flag change.
REQ-013 SHALL hold product=1 on BUSY entry; each BUSY cycle: product=product*count, count=count-1, while count>1.
REQ-014 SHALL leave BUSY when count<=1, which is N-1 cycles for N>=2 and exactly 1 cycle for N=0 or N=1, then enter DONE with RESULT=product.
REQ-015 SHALL, for N>12 (32-bit overflow), skip multiplication, spend 1 BUSY cycle, set err=1, RESULT=0.
REQ-016 SHALL keep product DATA_W bits wide; upper multiply bits are discarded.
REQ-017 SHALL hold DONE, with done sticky and RESULT stable, until the next GO.
REQ-018 SHALL drive rd as follows: a=0 gives zero-extended N; a=1 gives 0; a=2 gives {.., busy[2], err[1], done[0]}; a=3 gives RESULT.
REQ-019 SHALL ignore writes to a=2 and a=3.
REQ-020 SHALL let a write to N during BUSY affect only the next GO, never the running computation.
REQ-021 SHALL give GO precedence over a same-cycle DONE transition only when the state is already DONE.

Reset
REQ-022 SHALL force, on rst=0 (asynchronously, including mid-BUSY): state IDLE, N=0, count=0, product=0, RESULT=0, done=0, err=0, busy=0.
REQ-023 SHALL resume normal operation on the first rising clk after rst deasserts.

Configuration
REQ-024 SHALL, with macro FACT_ACCEL_IRQ_EN defined, add output port irq (1 bit) that is high for exactly one clk on the BUSY->DONE transition, and 0 at reset.
REQ-025 SHALL, without FACT_ACCEL_IRQ_EN, have no irq port and no irq logic; all other behaviour is identical.

Structure
REQ-026 SHALL place register offsets (N, GO, STATUS, RESULT), STATUS bit indices, FSM state encodings and the overflow limit constant (12) in shared package fact_pkg.
REQ-027 SHALL place the iterative product/count datapath in sub-module fact_core (inputs start and n; outputs product, last, ovf), with fact_accel holding the FSM and the bus registers.

Verification
REQ-028 SHALL cover: write N=5, GO -> busy for 4 cycles, then done=1, err=0, RESULT=120 (0x78).
REQ-029 SHALL cover: N=0 and N=1, each with GO -> 1 BUSY cycle, then done=1, RESULT=1.
REQ-030 SHALL cover: N=12 -> RESULT=479001600 after 11 BUSY cycles; N=13 -> err=1, done=1, RESULT=0 after 1 cycle.
REQ-031 SHALL cover: N=6 with GO, then GO again plus write N=3 on BUSY cycle 2 -> RESULT=720; a following GO then yields 6.
REQ-032 SHALL cover: rst=0 asserted mid-BUSY with N=9 -> all STATUS bits and RESULT read 0 immediately; the next GO with N=4 yields 24.
REQ-033 SHALL cover, with FACT_ACCEL_IRQ_EN defined: N=3 -> irq high for exactly one cycle, coincident with the first cycle of done=1.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared constants for the factorial accelerator: bus register offsets,
// STATUS bit positions, FSM state encoding and the largest N whose
// factorial fits in a 32-bit result.
package fact_pkg;

  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;
  localparam int STAT_BUSY = 2;

  // 12! is the largest factorial that fits in 32 bits.
  localparam int unsigned OVF_LIMIT = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fact_core.sv
// Iterative factorial datapath: one multiply per enabled cycle.
// 'product' is the value the running product takes after the current
// step, so the controller can capture the final answer on the same cycle
// 'last' is raised. 'last' fires when this step brings the count to 1 or
// below, which yields N-1 steps for N>=2 and a single step for N<=1.
module fact_core
  import fact_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic [N_W-1:0]    n,
  output logic [DATA_W-1:0] product,
  output logic              last,
  output logic              ovf
);

  logic [N_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0] product_q, product_d;
  logic              ovf_q, ovf_d;

  // Upper multiply bits fall off because the product is kept DATA_W wide.
  assign product = (count_q > N_W'(1)) ? product_q * DATA_W'(count_q) : product_q;
  assign last    = ovf_q || (count_q <= N_W'(2));
  assign ovf     = ovf_q;

  // Next-state: load on start, otherwise step while enabled and not finished.
  always_comb begin
    count_d   = count_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    if (start) begin
      count_d   = n;
      product_d = DATA_W'(1);
      ovf_d     = (32'(n) > OVF_LIMIT);
    end else if (en && !last) begin
      product_d = product;
      count_d   = count_q - N_W'(1);
    end
  end

  // Datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: rtl/fact_accel.sv
// Bus-mapped factorial accelerator: N / GO / STATUS / RESULT registers,
// an IDLE-BUSY-DONE controller and the fact_core datapath.
// Optional feature: define FACT_ACCEL_IRQ_EN to add a one-cycle 'irq'
// output pulsed on the BUSY->DONE transition.
module fact_accel
  import fact_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
`ifdef FACT_ACCEL_IRQ_EN
  ,
  output logic              irq
`endif
);

  state_e            state_q;
  logic [N_W-1:0]    n_q;
  logic [DATA_W-1:0] result_q;
  logic              done_q;
  logic              err_q;
  logic              busy;
  logic              go;
  logic              core_start;
  logic              core_en;
  logic [DATA_W-1:0] core_product;
  logic              core_last;
  logic              core_ovf;
  logic              wd_unused;

  // Only the low N_W bits and bit 0 of the write data carry meaning.
  assign wd_unused = ^wd;

  assign busy       = (state_q == ST_BUSY);
  assign go         = we && (a == ADDR_GO) && wd[0];
  // GO is ignored while a computation is running.
  assign core_start = go && !busy;
  assign core_en    = busy;

  fact_core #(
    .DATA_W (DATA_W),
    .N_W    (N_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .en      (core_en),
    .n       (n_q),
    .product (core_product),
    .last    (core_last),
    .ovf     (core_ovf)
  );

  // Operand register; writable in any state, only sampled by the core on GO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q <= '0;
    end else if (we && (a == ADDR_N)) begin
      n_q <= wd[N_W-1:0];
    end
  end

`ifdef FACT_ACCEL_IRQ_EN
  logic irq_q;
  assign irq = irq_q;
`endif

  // Controller FSM with registered status, result and interrupt outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef FACT_ACCEL_IRQ_EN
      irq_q    <= 1'b0;
`endif
    end else begin
`ifdef FACT_ACCEL_IRQ_EN
      irq_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            state_q <= ST_BUSY;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (core_last) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            err_q    <= core_ovf;
            result_q <= core_ovf ? '0 : core_product;
`ifdef FACT_ACCEL_IRQ_EN
            irq_q    <= 1'b1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Combinational read mux; GO reads back as zero.
  always_comb begin
    rd = '0;
    case (a)
      ADDR_N:      rd = DATA_W'(n_q);
      ADDR_GO:     rd = '0;
      ADDR_STATUS: begin
        rd[STAT_BUSY] = busy;
        rd[STAT_ERR]  = err_q;
        rd[STAT_DONE] = done_q;
      end
      ADDR_RESULT: rd = result_q;
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Directed self-checking bench for fact_accel.
module tb_fact_accel;

  localparam logic [1:0] A_N = 2'd0, A_GO = 2'd1, A_ST = 2'd2, A_RES = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
`ifdef FACT_ACCEL_IRQ_EN
  logic        irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  fact_accel #(
    .DATA_W (32),
    .N_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .a   (a),
    .wd  (wd),
    .rd  (rd)
`ifdef FACT_ACCEL_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called in the low phase; the write is taken on the next rising edge.
  task automatic bus_wr(input logic [1:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] addr, output logic [31:0] data);
    a = addr;
    #1;
    data = rd;
  endtask

  // Counts low phases in which busy reads 1, bounded.
  task automatic wait_done(output int cyc);
    logic [31:0] s;
    cyc = 0;
    bus_rd(A_ST, s);
    while (s[2] && cyc < 100) begin
      cyc++;
      @(negedge clk);
      bus_rd(A_ST, s);
    end
  endtask

  task automatic run_fact(input logic [31:0] n, output int cyc);
    bus_wr(A_N, n);
    bus_wr(A_GO, 32'd1);
    wait_done(cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          cyc;
    int          irq_cnt;
    logic        seen;
    logic        irq_first;

    we = 1'b0; a = 2'd0; wd = '0; rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    bus_rd(A_N, v);   check("rst_n", v, 32'd0);
    bus_rd(A_ST, v);  check("rst_status", v, 32'd0);
    bus_rd(A_RES, v); check("rst_result", v, 32'd0);
`ifdef FACT_ACCEL_IRQ_EN
    check("rst_irq", {31'd0, irq}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // N=5: 4 busy cycles, 120
    bus_wr(A_N, 32'd5);
    bus_rd(A_N, v);  check("n_readback", v, 32'd5);
    bus_rd(A_GO, v); check("go_reads_zero", v, 32'd0);
    bus_wr(A_GO, 32'd1);
    wait_done(cyc);
    check("n5_cycles", cyc, 32'd4);
    bus_rd(A_ST, v);  check("n5_status", v, 32'h1);
    bus_rd(A_RES, v); check("n5_result", v, 32'd120);
    repeat (3) @(negedge clk);
    bus_rd(A_ST, v);  check("n5_hold_status", v, 32'h1);
    bus_rd(A_RES, v); check("n5_hold_result", v, 32'd120);
    bus_wr(A_RES, 32'hDEAD_BEEF);
    bus_wr(A_ST, 32'h7);
    bus_wr(A_GO, 32'h2);
    bus_rd(A_RES, v); check("ro_result", v, 32'd120);
    bus_rd(A_ST, v);  check("ro_status", v, 32'h1);

    // N=0 and N=1: single busy cycle, result 1
    run_fact(32'd0, cyc);
    check("n0_cycles", cyc, 32'd1);
    bus_rd(A_RES, v); check("n0_result", v, 32'd1);
    run_fact(32'd1, cyc);
    check("n1_cycles", cyc, 32'd1);
    bus_rd(A_RES, v); check("n1_result", v, 32'd1);
    bus_rd(A_ST, v);  check("n1_status", v, 32'h1);

    // N=12 fits, N=13 overflows
    run_fact(32'd12, cyc);
    check("n12_cycles", cyc, 32'd11);
    bus_rd(A_RES, v); check("n12_result", v, 32'd479001600);
    run_fact(32'd13, cyc);
    check("n13_cycles", cyc, 32'd1);
    bus_rd(A_ST, v);  check("n13_status", v, 32'h3);
    bus_rd(A_RES, v); check("n13_result", v, 32'd0);
    run_fact(32'd2, cyc);
    bus_rd(A_ST, v);  check("n2_err_cleared", v, 32'h1);
    bus_rd(A_RES, v); check("n2_result", v, 32'd2);

    // GO and N write while busy do not disturb the running computation
    bus_wr(A_N, 32'd6);
    bus_wr(A_GO, 32'd1);
    bus_wr(A_GO, 32'd1);
    bus_wr(A_N, 32'd3);
    bus_rd(A_ST, v);  check("n6_still_busy", v, 32'h4);
    wait_done(cyc);
    check("n6_remaining", cyc, 32'd3);
    bus_rd(A_RES, v); check("n6_result", v, 32'd720);
    bus_rd(A_N, v);   check("n6_new_n", v, 32'd3);
    bus_wr(A_GO, 32'd1);
    wait_done(cyc);
    bus_rd(A_RES, v); check("n3_after_result", v, 32'd6);

    // Asynchronous reset mid-computation
    bus_wr(A_N, 32'd9);
    bus_wr(A_GO, 32'd1);
    @(negedge clk);
    bus_rd(A_ST, v);  check("n9_busy", v, 32'h4);
    #1 rst = 1'b0;
    bus_rd(A_ST, v);  check("midrst_status", v, 32'd0);
    bus_rd(A_RES, v); check("midrst_result", v, 32'd0);
    bus_rd(A_N, v);   check("midrst_n", v, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_fact(32'd4, cyc);
    check("n4_cycles", cyc, 32'd3);
    bus_rd(A_RES, v); check("n4_result", v, 32'd24);

`ifdef FACT_ACCEL_IRQ_EN
    // irq: one pulse, aligned with the first done cycle
    bus_wr(A_N, 32'd3);
    bus_wr(A_GO, 32'd1);
    irq_cnt = 0; seen = 1'b0; irq_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_rd(A_ST, v);
      if (v[0] && !seen) begin
        seen = 1'b1;
        irq_first = irq;
      end
      if (irq) irq_cnt++;
      @(negedge clk);
    end
    check("irq_count", irq_cnt, 32'd1);
    check("irq_at_done", {31'd0, irq_first}, 32'd1);
    bus_rd(A_RES, v); check("irq_n3_result", v, 32'd6);
`else
    irq_cnt = 0; seen = 1'b0; irq_first = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
